// File: rtl/ser_xmt.sv
// 8N1 serial transmitter with a small transmit FIFO between the register-side
// write strobe and the TxD line. The line is idle high and driven from a flop.
module ser_xmt #(
  parameter int unsigned BIT_TICKS  = 1302,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] parallel_in,
  output logic       full,
  output logic       idle,
  output logic       serial_out
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(BIT_TICKS * STOP_BITS);

  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_TICKS - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS * BIT_TICKS - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [AW:0]   OCC_ONE   = (AW+1)'(1);
  localparam logic [AW:0]   OCC_FULL  = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   occ;
  logic [AW:0]   occ_next;
  logic [CW-1:0] cnt;
  logic [2:0]    bitcnt;
  logic [7:0]    shift;
  logic          empty;
  logic          push;
  logic          pop;
  logic          to_idle;

  // A pop in the same cycle frees a slot, so a write is accepted even when full.
  always_comb begin
    empty    = (occ == '0);
    pop      = !empty && ((state == IDLE) || ((state == STOP) && (cnt == '0)));
    push     = load && (!full || pop);
    to_idle  = empty && ((state == IDLE) || ((state == STOP) && (cnt == '0)));
    occ_next = occ;
    case ({push, pop})
      2'b10:   occ_next = occ + OCC_ONE;
      2'b01:   occ_next = occ - OCC_ONE;
      default: occ_next = occ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      full   <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= parallel_in;
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
      if (pop)
        rd_ptr <= rd_ptr + PTR_ONE;
      occ  <= occ_next;
      full <= (occ_next == OCC_FULL);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      serial_out <= 1'b1;
      idle       <= 1'b1;
      cnt        <= '0;
      bitcnt     <= '0;
      shift      <= '0;
    end else begin
      idle <= to_idle && (occ_next == '0);
      case (state)
        IDLE: begin
          if (pop) begin
            shift      <= mem[rd_ptr];
            bitcnt     <= '0;
            cnt        <= BIT_LAST;
            serial_out <= 1'b0;
            state      <= START;
          end else begin
            serial_out <= 1'b1;
          end
        end
        START: begin
          if (cnt == '0) begin
            cnt        <= BIT_LAST;
            serial_out <= shift[0];
            state      <= DATA;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        DATA: begin
          if (cnt == '0) begin
            if (bitcnt == 3'd7) begin
              cnt        <= STOP_LAST;
              serial_out <= 1'b1;
              state      <= STOP;
            end else begin
              // Line takes the next bit directly so it changes on the same edge as the shift.
              shift      <= {1'b0, shift[7:1]};
              serial_out <= shift[1];
              bitcnt     <= bitcnt + 3'd1;
              cnt        <= BIT_LAST;
            end
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        STOP: begin
          if (cnt == '0) begin
            if (pop) begin
              shift      <= mem[rd_ptr];
              bitcnt     <= '0;
              cnt        <= BIT_LAST;
              serial_out <= 1'b0;
              state      <= START;
            end else begin
              serial_out <= 1'b1;
              state      <= IDLE;
            end
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        default: begin
          serial_out <= 1'b1;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ser_xmt.sv
// Directed bench for ser_xmt: full-rate single frame, plus short-bit-period
// instances for back-to-back, FIFO-full, reset-abort and two-stop-bit cases.
module tb_ser_xmt;

  logic clk;
  int   checks = 0;
  int   errs   = 0;

  logic       a_reset, a_load, a_full, a_idle, a_so;
  logic [7:0] a_din;
  logic       b_reset, b_load, b_full, b_idle, b_so;
  logic [7:0] b_din;
  logic       c_reset, c_load, c_full, c_idle, c_so;
  logic [7:0] c_din;

  logic [511:0] b_line, b_idle_tr, b_full_tr, c_line, exp_line;

  ser_xmt #(.BIT_TICKS(1302), .STOP_BITS(1), .FIFO_DEPTH(4)) u_a (
    .clk(clk), .reset(a_reset), .load(a_load), .parallel_in(a_din),
    .full(a_full), .idle(a_idle), .serial_out(a_so));

  ser_xmt #(.BIT_TICKS(8), .STOP_BITS(1), .FIFO_DEPTH(4)) u_b (
    .clk(clk), .reset(b_reset), .load(b_load), .parallel_in(b_din),
    .full(b_full), .idle(b_idle), .serial_out(b_so));

  ser_xmt #(.BIT_TICKS(4), .STOP_BITS(2), .FIFO_DEPTH(4)) u_c (
    .clk(clk), .reset(c_reset), .load(c_load), .parallel_in(c_din),
    .full(c_full), .idle(c_idle), .serial_out(c_so));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected line waveform for one frame starting at sample index pos.
  task automatic put_frame(inout logic [511:0] v, input int pos, input logic [7:0] d,
                           input int bt, input int sb);
    for (int c = 0; c < bt; c++) v[pos + c] = 1'b0;
    for (int b = 0; b < 8; b++)
      for (int c = 0; c < bt; c++) v[pos + bt + b * bt + c] = d[b];
    for (int c = 0; c < sb * bt; c++) v[pos + 9 * bt + c] = 1'b1;
  endtask

  task automatic b_grab(input int n);
    b_line = '1; b_idle_tr = '0; b_full_tr = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      b_line[i] = b_so; b_idle_tr[i] = b_idle; b_full_tr[i] = b_full;
    end
  endtask

  task automatic c_grab(input int n);
    c_line = '1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      c_line[i] = c_so;
    end
  endtask

  task automatic test_reset;
    a_reset = 1'b1; b_reset = 1'b1; c_reset = 1'b1;
    a_load = 1'b0; b_load = 1'b0; c_load = 1'b0;
    a_din = '0; b_din = '0; c_din = '0;
    repeat (3) @(negedge clk);
    checks++; if (a_so !== 1'b1)   begin errs++; $display("FAIL rst_a_so: got %b want 1", a_so); end
    checks++; if (a_full !== 1'b0) begin errs++; $display("FAIL rst_a_full: got %b want 0", a_full); end
    checks++; if (a_idle !== 1'b1) begin errs++; $display("FAIL rst_a_idle: got %b want 1", a_idle); end
    checks++; if (b_so !== 1'b1)   begin errs++; $display("FAIL rst_b_so: got %b want 1", b_so); end
    checks++; if (b_full !== 1'b0) begin errs++; $display("FAIL rst_b_full: got %b want 0", b_full); end
    checks++; if (b_idle !== 1'b1) begin errs++; $display("FAIL rst_b_idle: got %b want 1", b_idle); end
    checks++; if (c_so !== 1'b1)   begin errs++; $display("FAIL rst_c_so: got %b want 1", c_so); end
    checks++; if (c_full !== 1'b0) begin errs++; $display("FAIL rst_c_full: got %b want 0", c_full); end
    checks++; if (c_idle !== 1'b1) begin errs++; $display("FAIL rst_c_idle: got %b want 1", c_idle); end
    a_reset = 1'b0; b_reset = 1'b0; c_reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_frame;
    logic [7:0] d;
    logic       lvl;
    logic       full_seen;
    logic       idle_last;
    int         hits;
    d = 8'h55; full_seen = 1'b0; idle_last = 1'bx;
    a_load = 1'b1; a_din = d;
    @(negedge clk);
    a_load = 1'b0; a_din = 8'h00;
    checks++; if (a_so !== 1'b1)   begin errs++; $display("FAIL sf_latency_hi: got %b want 1", a_so); end
    checks++; if (a_idle !== 1'b0) begin errs++; $display("FAIL sf_idle_fall: got %b want 0", a_idle); end
    for (int k = 0; k < 10; k++) begin
      if (k == 0)      lvl = 1'b0;
      else if (k == 9) lvl = 1'b1;
      else             lvl = d[k - 1];
      hits = 0;
      for (int c = 0; c < 1302; c++) begin
        @(negedge clk);
        if (a_so === lvl) hits++;
        full_seen |= a_full;
        if (k == 9 && c == 1301) idle_last = a_idle;
      end
      checks++;
      if (hits !== 1302) begin
        errs++; $display("FAIL sf_bit%0d: got %0d cycles at %b want 1302", k, hits, lvl);
      end
    end
    checks++; if (idle_last !== 1'b0) begin errs++; $display("FAIL sf_idle_last_stop: got %b want 0", idle_last); end
    checks++; if (full_seen !== 1'b0) begin errs++; $display("FAIL sf_full: got %b want 0", full_seen); end
    @(negedge clk);
    checks++; if (a_idle !== 1'b1) begin errs++; $display("FAIL sf_idle_end: got %b want 1", a_idle); end
    checks++; if (a_so !== 1'b1)   begin errs++; $display("FAIL sf_so_end: got %b want 1", a_so); end
  endtask

  task automatic test_back_to_back;
    b_load = 1'b1; b_din = 8'h00;
    fork
      begin
        @(negedge clk); b_din = 8'hFF;
        @(negedge clk); b_din = 8'hA5;
        @(negedge clk); b_load = 1'b0; b_din = 8'h5A;
      end
      b_grab(250);
    join
    exp_line = '1;
    put_frame(exp_line, 1, 8'h00, 8, 1);
    put_frame(exp_line, 81, 8'hFF, 8, 1);
    put_frame(exp_line, 161, 8'hA5, 8, 1);
    checks++; if (b_line !== exp_line) begin errs++; $display("FAIL b2b_line: got %h want %h", b_line, exp_line); end
    checks++; if (b_full_tr !== '0) begin errs++; $display("FAIL b2b_full: got %h want 0", b_full_tr); end
    checks++; if (b_idle_tr[0] !== 1'b0) begin errs++; $display("FAIL b2b_idle0: got %b want 0", b_idle_tr[0]); end
    checks++; if (b_idle_tr[240] !== 1'b0) begin errs++; $display("FAIL b2b_idle240: got %b want 0", b_idle_tr[240]); end
    checks++; if (b_idle_tr[241] !== 1'b1) begin errs++; $display("FAIL b2b_idle241: got %b want 1", b_idle_tr[241]); end
  endtask

  task automatic test_overflow;
    b_load = 1'b1; b_din = 8'h01;
    fork
      begin
        for (int k = 2; k <= 6; k++) begin
          @(negedge clk); b_din = 8'(k);
        end
        @(negedge clk); b_load = 1'b0; b_din = 8'h00;
      end
      b_grab(420);
    join
    exp_line = '1;
    for (int k = 0; k < 5; k++) put_frame(exp_line, 1 + 80 * k, 8'(k + 1), 8, 1);
    checks++; if (b_line !== exp_line) begin errs++; $display("FAIL ovf_line: got %h want %h", b_line, exp_line); end
    checks++; if (b_full_tr[3] !== 1'b0)  begin errs++; $display("FAIL ovf_full3: got %b want 0", b_full_tr[3]); end
    checks++; if (b_full_tr[4] !== 1'b1)  begin errs++; $display("FAIL ovf_full4: got %b want 1", b_full_tr[4]); end
    checks++; if (b_full_tr[80] !== 1'b1) begin errs++; $display("FAIL ovf_full80: got %b want 1", b_full_tr[80]); end
    checks++; if (b_full_tr[81] !== 1'b0) begin errs++; $display("FAIL ovf_full81: got %b want 0", b_full_tr[81]); end
    checks++; if (b_idle_tr[400] !== 1'b0) begin errs++; $display("FAIL ovf_idle400: got %b want 0", b_idle_tr[400]); end
    checks++; if (b_idle_tr[401] !== 1'b1) begin errs++; $display("FAIL ovf_idle401: got %b want 1", b_idle_tr[401]); end
  endtask

  task automatic test_full_push_pop;
    b_load = 1'b1; b_din = 8'h11;
    fork
      begin
        for (int k = 1; k <= 4; k++) begin
          @(negedge clk); b_din = 8'(8'h11 + k);
        end
        @(negedge clk); b_load = 1'b0; b_din = 8'h00;
        repeat (76) @(negedge clk);
        b_load = 1'b1; b_din = 8'h16;
        @(negedge clk); b_load = 1'b0; b_din = 8'h00;
      end
      b_grab(500);
    join
    exp_line = '1;
    for (int k = 0; k < 6; k++) put_frame(exp_line, 1 + 80 * k, 8'(8'h11 + k), 8, 1);
    checks++; if (b_line !== exp_line) begin errs++; $display("FAIL fpp_line: got %h want %h", b_line, exp_line); end
    checks++; if (b_full_tr[80] !== 1'b1)  begin errs++; $display("FAIL fpp_full80: got %b want 1", b_full_tr[80]); end
    checks++; if (b_full_tr[81] !== 1'b1)  begin errs++; $display("FAIL fpp_full81: got %b want 1", b_full_tr[81]); end
    checks++; if (b_full_tr[161] !== 1'b0) begin errs++; $display("FAIL fpp_full161: got %b want 0", b_full_tr[161]); end
    checks++; if (b_idle_tr[481] !== 1'b1) begin errs++; $display("FAIL fpp_idle481: got %b want 1", b_idle_tr[481]); end
  endtask

  task automatic test_reset_mid_frame;
    b_load = 1'b1; b_din = 8'h00;
    @(negedge clk); b_din = 8'h3C;
    @(negedge clk); b_load = 1'b0; b_din = 8'h00;
    repeat (38) @(negedge clk);
    checks++; if (b_so !== 1'b0) begin errs++; $display("FAIL rmf_mid_data: got %b want 0", b_so); end
    b_reset = 1'b1;
    @(negedge clk);
    b_reset = 1'b0;
    checks++; if (b_so !== 1'b1)   begin errs++; $display("FAIL rmf_so: got %b want 1", b_so); end
    checks++; if (b_idle !== 1'b1) begin errs++; $display("FAIL rmf_idle: got %b want 1", b_idle); end
    checks++; if (b_full !== 1'b0) begin errs++; $display("FAIL rmf_full: got %b want 0", b_full); end
    b_grab(30);
    checks++; if (b_line !== '1) begin errs++; $display("FAIL rmf_quiet: got %h want all ones", b_line); end
    checks++; if (b_idle_tr[29:0] !== 30'h3FFF_FFFF) begin errs++; $display("FAIL rmf_idle_hold: got %h want 3fffffff", b_idle_tr[29:0]); end
    @(negedge clk);
    b_load = 1'b1; b_din = 8'h81;
    fork
      begin @(negedge clk); b_load = 1'b0; b_din = 8'h00; end
      b_grab(90);
    join
    exp_line = '1;
    put_frame(exp_line, 1, 8'h81, 8, 1);
    checks++; if (b_line !== exp_line) begin errs++; $display("FAIL rmf_line: got %h want %h", b_line, exp_line); end
    checks++; if (b_idle_tr[81] !== 1'b1) begin errs++; $display("FAIL rmf_idle81: got %b want 1", b_idle_tr[81]); end
  endtask

  task automatic test_two_stop;
    int run;
    c_load = 1'b1; c_din = 8'h16;
    fork
      begin
        @(negedge clk); c_din = 8'hE9;
        @(negedge clk); c_load = 1'b0; c_din = 8'h00;
      end
      c_grab(100);
    join
    exp_line = '1;
    put_frame(exp_line, 1, 8'h16, 4, 2);
    put_frame(exp_line, 45, 8'hE9, 4, 2);
    checks++; if (c_line !== exp_line) begin errs++; $display("FAIL ts_line: got %h want %h", c_line, exp_line); end
    run = 0;
    for (int i = 37; i < 100; i++) begin
      if (c_line[i] !== 1'b1) break;
      run++;
    end
    checks++; if (run !== 8) begin errs++; $display("FAIL ts_stop_len: got %0d want 8", run); end
    checks++; if (c_idle !== 1'b1) begin errs++; $display("FAIL ts_idle_end: got %b want 1", c_idle); end
  endtask

  initial begin
    test_reset;
    test_single_frame;
    test_back_to_back;
    test_overflow;
    test_full_push_pop;
    test_reset_mid_frame;
    test_two_stop;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errs);
    $finish;
  end

endmodule
